// File: rtl/des_key_pkg.sv
// DES key-schedule shared types, FIPS 46-3 permutation tables
// and the PC1/PC2 helpers used by the schedule generator.
package des_key_pkg;

  localparam logic [15:0] DES_SHIFT_MASK = 16'h7EFC;

  typedef enum logic {
    ENC = 1'b0,
    DEC = 1'b1
  } mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Entries are 1-based FIPS bit numbers of the source vector
  localparam int PC1_TABLE [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TABLE [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  function automatic logic [55:0] pc1(input logic [63:0] key);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) begin
      r[i] = key[6'(PC1_TABLE[i] - 1)];
    end
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) begin
      r[i] = cd[6'(PC2_TABLE[i] - 1)];
    end
    return r;
  endfunction

  // Total rotation over n rounds: one place per round plus the mask extras
  function automatic int shift_total(input logic [15:0] m, input int n);
    int t;
    t = n;
    for (int i = 0; i < 16; i++) begin
      if (i < n && m[i]) t++;
    end
    return t;
  endfunction

endpackage

// File: rtl/des_cd_rotator.sv
// Combinational C/D rotator: both 28-bit halves rotate by 0, 1
// or 2 places, left (encrypt order) or right (decrypt order).
module des_cd_rotator (
  input  logic [55:0] cd_i,
  input  logic [1:0]  amt_i,
  input  logic        left_i,
  output logic [55:0] cd_o
);

  // Left by one means new[i] = old[i+1], so it is a vector right shift
  function automatic logic [27:0] rot(
    input logic [27:0] h,
    input logic [1:0]  n,
    input logic        l
  );
    logic [27:0] r;
    r = h;
    unique case (1'b1)
      (n == 2'd1 &&  l): r = {h[0], h[27:1]};
      (n == 2'd2 &&  l): r = {h[1:0], h[27:2]};
      (n == 2'd1 && !l): r = {h[26:0], h[27]};
      (n == 2'd2 && !l): r = {h[25:0], h[27:26]};
      default:           r = h;
    endcase
    return r;
  endfunction

  always_comb begin
    cd_o = '0;
    cd_o[27:0]  = rot(cd_i[27:0], amt_i, left_i);
    cd_o[55:28] = rot(cd_i[55:28], amt_i, left_i);
  end

endmodule

// File: rtl/des_key_schedule.sv
// Sequential DES key schedule: PC1 on accept, then one PC2
// subkey per handshake in encrypt or decrypt round order.
module des_key_schedule
  import des_key_pkg::*;
#(
  parameter int          ROUNDS       = 16,
  parameter logic [15:0] SHIFT_MASK   = DES_SHIFT_MASK,
  parameter bit          CHECK_PARITY = 1'b1,
  localparam int         RW = (ROUNDS > 1) ? $clog2(ROUNDS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_valid,
  output logic          start_ready,
  input  logic [63:0]   key_in,
  input  logic          mode,
  input  logic          abort,
  output logic          sk_valid,
  input  logic          sk_ready,
  output logic [47:0]   sk_data,
  output logic [RW-1:0] sk_round,
  output logic          sk_last,
  output logic          parity_err,
  output logic          busy
);

  if (ROUNDS < 1 || ROUNDS > 16) begin : g_bad_rounds
    $error("des_key_schedule: ROUNDS must be in 1..16");
  end

  // Decrypt order relies on the halves returning to C0D0 after all rounds
  if (shift_total(SHIFT_MASK, ROUNDS) != 28) begin : g_bad_mask
    $error("des_key_schedule: ROUNDS + popcount(SHIFT_MASK) must be 28");
  end

  state_e        state_q, state_d;
  mode_e         mode_q, mode_d;
  logic [55:0]   cd_q, cd_d;
  logic [55:0]   cd_next;
  logic [RW-1:0] round_q, round_d;
  logic          perr_q, perr_d;

  logic [4:0]    sh_idx;
  logic [1:0]    rot_amt;
  logic          rot_left;
  logic [7:0]    byte_even;
  logic          run;
  logic          accept;

  assign run    = (state_q == RUN);
  assign accept = (state_q == IDLE) && start_valid && !abort;

  always_comb begin
    sh_idx   = 5'(round_q);
    rot_left = 1'b1;
    if (mode_q == DEC) begin
      sh_idx   = 5'(ROUNDS) - 5'(round_q);
      rot_left = 1'b0;
    end
    rot_amt = 2'd1 + {1'b0, SHIFT_MASK[sh_idx[3:0]]};
    // Decrypt round 0 uses C0D0 directly since it equals C16D16
    if (mode_q == DEC && round_q == '0) begin
      rot_amt = 2'd0;
    end
  end

  des_cd_rotator u_rot (
    .cd_i   (cd_q),
    .amt_i  (rot_amt),
    .left_i (rot_left),
    .cd_o   (cd_next)
  );

  always_comb begin
    byte_even = '0;
    for (int b = 0; b < 8; b++) begin
      byte_even[b] = ~^key_in[8*b +: 8];
    end
  end

  assign start_ready = !run;
  assign busy        = run;
  assign sk_valid    = run;
  assign sk_round    = round_q;
  assign sk_last     = run && (round_q == RW'(ROUNDS - 1));
  assign sk_data     = pc2(cd_next);
  assign parity_err  = perr_q;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cd_d    = cd_q;
    round_d = round_q;
    perr_d  = perr_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RUN;
          mode_d  = mode_e'(mode);
          cd_d    = pc1(key_in);
          round_d = '0;
          perr_d  = CHECK_PARITY && (|byte_even);
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
          round_d = '0;
        end else if (sk_ready) begin
          cd_d    = cd_next;
          round_d = round_q + 1'b1;
          if (sk_last) begin
            state_d = IDLE;
            round_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= ENC;
      cd_q    <= '0;
      round_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cd_q    <= cd_d;
      round_q <= round_d;
      perr_q  <= perr_d;
    end
  end

endmodule

// File: tb/tb_des_key_schedule.sv
// Randomised bench for des_key_schedule against a table-driven
// DES key-schedule model using cumulative rotation offsets.
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_valid;
  logic        start_ready;
  logic [63:0] key_in;
  logic        mode;
  logic        abort;
  logic        sk_valid;
  logic        sk_ready;
  logic [47:0] sk_data;
  logic [3:0]  sk_round;
  logic        sk_last;
  logic        parity_err;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  des_key_schedule dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_valid (start_valid),
    .start_ready (start_ready),
    .key_in      (key_in),
    .mode        (mode),
    .abort       (abort),
    .sk_valid    (sk_valid),
    .sk_ready    (sk_ready),
    .sk_data     (sk_data),
    .sk_round    (sk_round),
    .sk_last     (sk_last),
    .parity_err  (parity_err),
    .busy        (busy)
  );

  localparam int PC1 [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  localparam int PC2 [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic [47:0] exp_sk [16];
  logic [47:0] got_sk [16];
  logic        exp_perr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] bitrev64(input logic [63:0] v);
    logic [63:0] r;
    for (int i = 0; i < 64; i++) r[i] = v[63-i];
    return r;
  endfunction

  function automatic logic [47:0] bitrev48(input logic [47:0] v);
    logic [47:0] r;
    for (int i = 0; i < 48; i++) r[i] = v[47-i];
    return r;
  endfunction

  // Subkey k uses halves rotated left by the running sum of SHIFTS[0..k]
  task automatic build_model(input logic [63:0] key, input logic md);
    logic [55:0] cd0, cd;
    logic [47:0] enc [16];
    int t;
    for (int j = 0; j < 56; j++) cd0[j] = key[PC1[j]-1];
    t = 0;
    for (int k = 0; k < 16; k++) begin
      t += SHIFTS[k];
      for (int i = 0; i < 28; i++) begin
        cd[i]      = cd0[(i + t) % 28];
        cd[28 + i] = cd0[28 + (i + t) % 28];
      end
      for (int m = 0; m < 48; m++) enc[k][m] = cd[PC2[m]-1];
    end
    for (int k = 0; k < 16; k++) exp_sk[k] = md ? enc[15-k] : enc[k];
    exp_perr = 1'b0;
    for (int b = 0; b < 8; b++) begin
      if ($countones(key[8*b +: 8]) % 2 == 0) exp_perr = 1'b1;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start_ready"}, 64'(start_ready), 64'd1);
    check({tag, "_sk_valid"},    64'(sk_valid),    64'd0);
    check({tag, "_sk_last"},     64'(sk_last),     64'd0);
    check({tag, "_sk_round"},    64'(sk_round),    64'd0);
    check({tag, "_sk_data"},     64'(sk_data),     64'd0);
    check({tag, "_parity_err"},  64'(parity_err),  64'd0);
    check({tag, "_busy"},        64'(busy),        64'd0);
  endtask

  // stop_kind: 0 = run to completion, 1 = abort at stop_at, 2 = reset at stop_at
  task automatic run_sched(input logic [63:0] key, input logic md, input bit bp,
                           input int stop_at, input int stop_kind);
    int  hs;
    int  cyc;
    int  ready_cyc;
    bit  rdy;
    build_model(key, md);
    @(negedge clk);
    check("idle_start_ready", 64'(start_ready), 64'd1);
    start_valid = 1'b1;
    key_in      = key;
    mode        = md;
    sk_ready    = 1'b0;
    @(negedge clk);
    start_valid = 1'b0;
    check("accept_busy", 64'(busy), 64'd1);
    check("accept_start_ready", 64'(start_ready), 64'd0);
    hs = 0;
    cyc = 0;
    ready_cyc = 0;
    while (hs < 16 && cyc < 400) begin
      check("sk_valid", 64'(sk_valid), 64'd1);
      check($sformatf("sk_data_r%0d", hs), 64'(sk_data), 64'(exp_sk[hs]));
      check("sk_round", 64'(sk_round), 64'(hs));
      check("sk_last", 64'(sk_last), 64'(hs == 15));
      check("parity_err", 64'(parity_err), 64'(exp_perr));
      got_sk[hs] = sk_data;
      if (hs == stop_at && stop_kind == 1) begin
        start_valid = 1'b0;
        abort = 1'b1;
        sk_ready = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        sk_ready = 1'b0;
        check("abort_sk_valid", 64'(sk_valid), 64'd0);
        check("abort_start_ready", 64'(start_ready), 64'd1);
        check("abort_busy", 64'(busy), 64'd0);
        return;
      end
      if (hs == stop_at && stop_kind == 2) begin
        start_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      rdy = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
      sk_ready = rdy;
      // A key offered mid-schedule must be ignored
      start_valid = bp ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      cyc++;
      if (rdy) begin
        hs++;
        ready_cyc++;
      end
    end
    sk_ready = 1'b0;
    start_valid = 1'b0;
    if (cyc >= 400) check("timeout_handshakes", 64'(hs), 64'd16);
    if (!bp) check("burst_cycles", 64'(cyc), 64'd16);
    check("handshakes", 64'(ready_cyc), 64'd16);
    check("done_start_ready", 64'(start_ready), 64'd1);
    check("done_sk_valid", 64'(sk_valid), 64'd0);
    check("done_sk_last", 64'(sk_last), 64'd0);
    check("done_parity_err", 64'(parity_err), 64'(exp_perr));
  endtask

  initial begin
    logic [63:0] kat;
    rst_n       = 1'b0;
    start_valid = 1'b0;
    key_in      = '0;
    mode        = 1'b0;
    abort       = 1'b0;
    sk_ready    = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    kat = bitrev64(64'h133457799BBCDFF1);

    run_sched(kat, 1'b0, 1'b0, -1, 0);
    check("kat_enc_r0", 64'(got_sk[0]), 64'(bitrev48(48'h1B02EFFC7072)));
    check("kat_enc_r15", 64'(got_sk[15]), 64'(bitrev48(48'hCB3D8B0E17F5)));

    run_sched(kat, 1'b1, 1'b0, -1, 0);
    check("kat_dec_r0", 64'(got_sk[0]), 64'(bitrev48(48'hCB3D8B0E17F5)));
    check("kat_dec_r15", 64'(got_sk[15]), 64'(bitrev48(48'h1B02EFFC7072)));

    run_sched(kat, 1'b0, 1'b1, -1, 0);
    run_sched(kat ^ 64'h1, 1'b0, 1'b1, -1, 0);

    run_sched({$urandom, $urandom}, 1'b0, 1'b0, 5, 1);
    run_sched({$urandom, $urandom}, 1'b1, 1'b1, -1, 0);

    // Abort in IDLE outranks an offered key
    @(negedge clk);
    start_valid = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    abort = 1'b0;
    check("idle_abort_sk_valid", 64'(sk_valid), 64'd0);
    check("idle_abort_start_ready", 64'(start_ready), 64'd1);

    run_sched(kat, 1'b0, 1'b1, 8, 2);
    run_sched(kat, 1'b0, 1'b0, -1, 0);
    check("restart_kat_r0", 64'(got_sk[0]), 64'(bitrev48(48'h1B02EFFC7072)));
    check("restart_kat_r15", 64'(got_sk[15]), 64'(bitrev48(48'hCB3D8B0E17F5)));

    repeat (6) begin
      run_sched({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b1, -1, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
